// File: rtl/regfile_arbiter_pkg.sv
// Shared definitions for the register-file access arbiter: widths and read FSM states.
package regfile_arbiter_pkg;

   localparam int REG_ADDR_W = 3;
   localparam int REG_DATA_W = 16;

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_READ = 2'd1,
      RD_DONE = 2'd2
   } rd_state_t;

endpackage

// File: rtl/regfile_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. Requester 0 is the core and requester 1 is the debug
// monitor. A grant is only ever given to a valid requester, so every grant is a
// completed transfer and moves the priority to the other side.
module rr_arb2 (
   input  logic Clk,
   input  logic Reset,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1
);

   // Set when requester 1 wins a tie; cleared out of reset so the core is favoured.
   logic prio1;

   // Grants are combinational so the handshake completes in the request cycle.
   always_comb begin
      gnt0 = req0 && (!req1 || !prio1);
      gnt1 = req1 && (!req0 ||  prio1);
   end

   // Hand priority to whichever side was not just granted.
   always_ff @(posedge Clk) begin
      if (Reset)
         prio1 <= 1'b0;
      else if (gnt0)
         prio1 <= 1'b1;
      else if (gnt1)
         prio1 <= 1'b0;
   end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares the register-file write port between core writeback and the debug monitor,
// and steals idle SR1 read cycles to serve debug reads with write forwarding.
module regfile_arbiter
   import regfile_arbiter_pkg::*;
(
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  core_wr_valid,
   output logic                  core_wr_ready,
   input  logic [REG_ADDR_W-1:0] core_wr_addr,
   input  logic [REG_DATA_W-1:0] core_wr_data,
   input  logic                  dbg_wr_valid,
   output logic                  dbg_wr_ready,
   input  logic [REG_ADDR_W-1:0] dbg_wr_addr,
   input  logic [REG_DATA_W-1:0] dbg_wr_data,
   input  logic                  dbg_rd_valid,
   output logic                  dbg_rd_ready,
   input  logic [REG_ADDR_W-1:0] dbg_rd_addr,
   output logic                  dbg_rd_done,
   output logic [REG_DATA_W-1:0] dbg_rd_data,
   input  logic [REG_ADDR_W-1:0] core_sr1,
   input  logic                  core_rd_busy,
   output logic                  rf_ld,
   output logic [REG_ADDR_W-1:0] rf_dr,
   output logic [REG_DATA_W-1:0] rf_din,
   output logic [REG_ADDR_W-1:0] rf_sr1,
   input  logic [REG_DATA_W-1:0] rf_sr1_data
);

   logic                  core_gnt;
   logic                  dbg_gnt;
   rd_state_t             state_q;
   rd_state_t             state_d;
   logic                  capture;
   logic                  fwd_hit;
   logic [REG_ADDR_W-1:0] rd_addr_q;
   logic [REG_DATA_W-1:0] rd_data_q;

   rr_arb2 u_arb (
      .Clk   (Clk),
      .Reset (Reset),
      .req0  (core_wr_valid),
      .req1  (dbg_wr_valid),
      .gnt0  (core_gnt),
      .gnt1  (dbg_gnt)
   );

   assign core_wr_ready = core_gnt;
   assign dbg_wr_ready  = dbg_gnt;

   // Register the granted write for exactly one cycle on the register-file port.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         rf_ld  <= 1'b0;
         rf_dr  <= '0;
         rf_din <= '0;
      end else begin
         rf_ld <= core_gnt || dbg_gnt;
         if (core_gnt) begin
            rf_dr  <= core_wr_addr;
            rf_din <= core_wr_data;
         end else if (dbg_gnt) begin
            rf_dr  <= dbg_wr_addr;
            rf_din <= dbg_wr_data;
         end
      end
   end

   // Read FSM state register.
   always_ff @(posedge Clk) begin
      if (Reset)
         state_q <= RD_IDLE;
      else
         state_q <= state_d;
   end

   // Read FSM next state: the core keeps the SR1 port whenever it is busy.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RD_IDLE: if (dbg_rd_valid && !core_rd_busy) state_d = RD_READ;
         RD_READ: if (!core_rd_busy)                 state_d = RD_DONE;
         RD_DONE:                                    state_d = RD_IDLE;
         default:                                    state_d = RD_IDLE;
      endcase
   end

   // Read FSM outputs: handshake, SR1 steering and capture strobe.
   always_comb begin
      dbg_rd_ready = 1'b0;
      dbg_rd_done  = 1'b0;
      rf_sr1       = core_sr1;
      capture      = 1'b0;
      case (state_q)
         RD_IDLE: dbg_rd_ready = dbg_rd_valid && !core_rd_busy;
         RD_READ: begin
            if (!core_rd_busy) begin
               rf_sr1  = rd_addr_q;
               capture = 1'b1;
            end
         end
         RD_DONE: dbg_rd_done = 1'b1;
         default: ;
      endcase
   end

   // A write sitting on the port this cycle lands after the read, so forward it.
   assign fwd_hit = rf_ld && (rf_dr == rd_addr_q);

   // Latch the debug read address on acceptance and the result on capture.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         rd_addr_q <= '0;
         rd_data_q <= '0;
      end else begin
         if (dbg_rd_ready)
            rd_addr_q <= dbg_rd_addr;
         if (capture)
            rd_data_q <= fwd_hit ? rf_din : rf_sr1_data;
      end
   end

   assign dbg_rd_data = rd_data_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: directed scenarios followed by randomized traffic,
// checked against a transaction-level model of the arbiter and register file.
module tb_regfile_arbiter;

   logic        Clk;
   logic        Reset;
   logic        core_wr_valid, core_wr_ready;
   logic [2:0]  core_wr_addr;
   logic [15:0] core_wr_data;
   logic        dbg_wr_valid, dbg_wr_ready;
   logic [2:0]  dbg_wr_addr;
   logic [15:0] dbg_wr_data;
   logic        dbg_rd_valid, dbg_rd_ready;
   logic [2:0]  dbg_rd_addr;
   logic        dbg_rd_done;
   logic [15:0] dbg_rd_data;
   logic [2:0]  core_sr1;
   logic        core_rd_busy;
   logic        rf_ld;
   logic [2:0]  rf_dr;
   logic [15:0] rf_din;
   logic [2:0]  rf_sr1;
   logic [15:0] rf_sr1_data;

   regfile_arbiter dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .core_wr_valid (core_wr_valid),
      .core_wr_ready (core_wr_ready),
      .core_wr_addr  (core_wr_addr),
      .core_wr_data  (core_wr_data),
      .dbg_wr_valid  (dbg_wr_valid),
      .dbg_wr_ready  (dbg_wr_ready),
      .dbg_wr_addr   (dbg_wr_addr),
      .dbg_wr_data   (dbg_wr_data),
      .dbg_rd_valid  (dbg_rd_valid),
      .dbg_rd_ready  (dbg_rd_ready),
      .dbg_rd_addr   (dbg_rd_addr),
      .dbg_rd_done   (dbg_rd_done),
      .dbg_rd_data   (dbg_rd_data),
      .core_sr1      (core_sr1),
      .core_rd_busy  (core_rd_busy),
      .rf_ld         (rf_ld),
      .rf_dr         (rf_dr),
      .rf_din        (rf_din),
      .rf_sr1        (rf_sr1),
      .rf_sr1_data   (rf_sr1_data)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Register file the block drives: written at the edge ending an rf_ld cycle.
   logic [15:0] env_rf [8];
   always @(posedge Clk) if (rf_ld) env_rf[rf_dr] <= rf_din;
   assign rf_sr1_data = env_rf[rf_sr1];

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state.
   bit          known = 1'b0;
   bit          pref_dbg;          // debug wins the next tie
   int          phase;             // 0 no read, 1 read pending, 2 result ready
   logic [2:0]  lat_addr;
   logic [15:0] mem [8];           // register contents as of all accepted writes
   logic        exp_ld, exp_done, chk_dp;
   logic [2:0]  exp_dr;
   logic [15:0] exp_din, exp_rd_data;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: check combinational outputs, advance the model, check registered outputs.
   task automatic cycle();
      logic gc, gd, cv, dv, rv, busy, rst;
      logic [2:0]  ca, da, ra, sr;
      logic [15:0] cd, dd;
      #1;
      cv = core_wr_valid; dv = dbg_wr_valid; rv = dbg_rd_valid;
      busy = core_rd_busy; rst = Reset; sr = core_sr1;
      ca = core_wr_addr; cd = core_wr_data; da = dbg_wr_addr; dd = dbg_wr_data;
      ra = dbg_rd_addr;
      gc = cv && (!dv || !pref_dbg);
      gd = dv && !gc;
      if (known) begin
         chk("core_wr_ready", 16'(core_wr_ready), 16'(gc));
         chk("dbg_wr_ready", 16'(dbg_wr_ready), 16'(gd));
         chk("dbg_rd_ready", 16'(dbg_rd_ready), 16'(phase == 0 && rv && !busy));
         chk("rf_sr1", 16'(rf_sr1), 16'((phase == 1 && !busy) ? lat_addr : sr));
      end
      @(posedge Clk);
      if (rst) begin
         pref_dbg = 1'b0; phase = 0; known = 1'b1; chk_dp = 1'b1;
         exp_ld = 1'b0; exp_dr = '0; exp_din = '0; exp_done = 1'b0; exp_rd_data = '0;
      end else begin
         exp_ld = gc || gd;
         chk_dp = exp_ld;
         if (gc) begin
            exp_dr = ca; exp_din = cd; pref_dbg = 1'b1;
         end else if (gd) begin
            exp_dr = da; exp_din = dd; pref_dbg = 1'b0;
         end
         exp_done = 1'b0;
         if (phase == 0) begin
            if (rv && !busy) begin lat_addr = ra; phase = 1; end
         end else if (phase == 1) begin
            if (!busy) begin exp_rd_data = mem[lat_addr]; exp_done = 1'b1; phase = 2; end
         end else begin
            phase = 0;
         end
         if (exp_ld) mem[exp_dr] = exp_din;
      end
      #1;
      if (known) begin
         chk("rf_ld", 16'(rf_ld), 16'(exp_ld));
         chk("dbg_rd_done", 16'(dbg_rd_done), 16'(exp_done));
         chk("dbg_rd_data", dbg_rd_data, exp_rd_data);
         if (chk_dp) begin
            chk("rf_dr", 16'(rf_dr), 16'(exp_dr));
            chk("rf_din", rf_din, exp_din);
         end
      end
      @(negedge Clk);
   endtask

   initial begin
      Reset = 1'b1;
      core_wr_valid = 0; core_wr_addr = 0; core_wr_data = 0;
      dbg_wr_valid = 0; dbg_wr_addr = 0; dbg_wr_data = 0;
      dbg_rd_valid = 0; dbg_rd_addr = 0; core_sr1 = 0; core_rd_busy = 0;
      for (int i = 0; i < 8; i++) mem[i] = '0;
      @(negedge Clk);
      cycle(); cycle();
      Reset = 1'b0;
      chk("reset_rf_ld", 16'(rf_ld), 16'h0);
      chk("reset_rd_data", dbg_rd_data, 16'h0);

      // Lone core write passes straight through.
      core_wr_valid = 1; core_wr_addr = 3; core_wr_data = 16'hBEEF;
      #1 chk("lone_core_ready", 16'(core_wr_ready), 16'h1);
      cycle();
      core_wr_valid = 0;
      chk("lone_rf_ld", 16'(rf_ld), 16'h1);
      chk("lone_rf_dr", 16'(rf_dr), 16'h3);
      chk("lone_rf_din", rf_din, 16'hBEEF);
      cycle();

      // Contention straight after reset alternates, starting with the core.
      Reset = 1; cycle(); Reset = 0;
      core_wr_valid = 1; core_wr_addr = 1; core_wr_data = 16'h1111;
      dbg_wr_valid = 1; dbg_wr_addr = 2; dbg_wr_data = 16'h2222;
      for (int i = 0; i < 4; i++) begin
         #1 chk("rr_core_ready", 16'(core_wr_ready), 16'(i % 2 == 0));
         cycle();
         chk("rr_rf_ld", 16'(rf_ld), 16'h1);
         chk("rr_rf_din", rf_din, (i % 2 == 0) ? 16'h1111 : 16'h2222);
      end
      core_wr_valid = 0; dbg_wr_valid = 0;
      cycle();

      // Give every register a known value.
      for (int r = 0; r < 8; r++) begin
         core_wr_valid = 1; core_wr_addr = 3'(r); core_wr_data = 16'($urandom);
         cycle();
      end
      core_wr_valid = 0;
      cycle();

      // Debug read of R5 held off while the core owns SR1.
      core_sr1 = 6; core_rd_busy = 1; dbg_rd_valid = 1; dbg_rd_addr = 5;
      cycle();
      core_rd_busy = 0;
      cycle();
      dbg_rd_valid = 0; core_rd_busy = 1;
      for (int i = 0; i < 3; i++) begin
         #1 chk("busy_sr1", 16'(rf_sr1), 16'h6);
         cycle();
      end
      core_rd_busy = 0;
      #1 chk("steal_sr1", 16'(rf_sr1), 16'h5);
      cycle();
      chk("r5_done", 16'(dbg_rd_done), 16'h1);
      chk("r5_data", dbg_rd_data, mem[5]);
      cycle();
      chk("r5_done_once", 16'(dbg_rd_done), 16'h0);

      // Write to R5 accepted one cycle before capture is forwarded.
      dbg_rd_valid = 1; dbg_rd_addr = 5;
      cycle();
      dbg_rd_valid = 0; core_rd_busy = 1;
      core_wr_valid = 1; core_wr_addr = 5; core_wr_data = 16'h1234;
      cycle();
      core_wr_valid = 0; core_rd_busy = 0;
      cycle();
      chk("fwd_done", 16'(dbg_rd_done), 16'h1);
      chk("fwd_data", dbg_rd_data, 16'h1234);
      cycle();

      // Reset while a read is pending and a write is accepted.
      dbg_rd_valid = 1; dbg_rd_addr = 2;
      cycle();
      dbg_rd_valid = 0; core_rd_busy = 1;
      core_wr_valid = 1; core_wr_addr = 4; core_wr_data = 16'hABCD;
      Reset = 1;
      cycle();
      Reset = 0; core_wr_valid = 0; core_rd_busy = 0;
      chk("rst_rf_ld", 16'(rf_ld), 16'h0);
      chk("rst_rf_dr", 16'(rf_dr), 16'h0);
      chk("rst_rf_din", rf_din, 16'h0);
      chk("rst_rd_data", dbg_rd_data, 16'h0);
      for (int i = 0; i < 2; i++) begin
         cycle();
         chk("rst_no_done", 16'(dbg_rd_done), 16'h0);
      end

      // Randomized traffic on all ports.
      for (int i = 0; i < 500; i++) begin
         Reset         = ($urandom % 64) == 0;
         core_wr_valid = 1'($urandom_range(0, 1));
         core_wr_addr  = 3'($urandom_range(0, 7));
         core_wr_data  = 16'($urandom);
         dbg_wr_valid  = 1'($urandom_range(0, 1));
         dbg_wr_addr   = 3'($urandom_range(0, 7));
         dbg_wr_data   = 16'($urandom);
         dbg_rd_valid  = 1'($urandom_range(0, 1));
         dbg_rd_addr   = 3'($urandom_range(0, 7));
         core_sr1      = 3'($urandom_range(0, 7));
         core_rd_busy  = 1'($urandom_range(0, 1));
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
